wb_writer: RTL and testbench
============================

// Module: wb_writer
// PURPOSE
//  Writeback-side driver of the dual-write-port register file. It registers main-pipe results onto
//  the normal port (write_enable/rd/write_data) and queues atomic/memory-unit results in a FIFO.
//  Queued results drain onto the atomic port (atomic_write_enable/atomic_rd/atomic_write_data).
//  Exports pending_mask so decode stalls on registers with an atomic write still in flight.
// PARAMETERS
//  XLEN   32  data width
//  DEPTH  4   atomic FIFO entries; power of two, >=2
// PORTS
//  clk                  in   1     clock, rising edge
//  reset                in   1     asynchronous, active-low reset
//  stall                in   1     writeback freeze: no writes issued, no FIFO pop
//  main_valid           in   1     main-pipe result valid (no backpressure)
//  main_rd              in   5     main destination register
//  main_data            in   XLEN  main result
//  atom_valid           in   1     atomic result offered
//  atom_ready           out  1     atomic result accepted when valid&&ready
//  atom_rd              in   5     atomic destination register
//  atom_data            in   XLEN  atomic result
//  write_enable         out  1     to regfile normal port
//  rd                   out  5
//  write_data           out  XLEN
//  atomic_write_enable  out  1     to regfile atomic port
//  atomic_rd            out  5
//  atomic_write_data    out  XLEN
//  pending_mask         out  32    bit r set: atomic write to r queued or on port; bit0 always 0
// BEHAVIOUR
//  - Reset (async assert): all outputs 0; FIFO empty; atom_ready=1 once reset deasserts.
//  - All write-port outputs are registered. Main latency is 1 cycle: main_valid at edge N gives
//    write_enable at N+1. The main input is ignored while stall=1.
//  - write_enable is set only for main_valid && !stall && main_rd!=0. rd and write_data always
//    load from the main inputs.
//  - FIFO push on atom_valid&&atom_ready. atom_ready=!full; a full FIFO takes no pass-through push,
//    even if it pops in the same cycle. Entries with rd=0 are queued normally.
//  - FIFO pop when !stall && !empty. The popped head loads the atomic output registers.
//    atomic_write_enable=1 only if head rd!=0; with stall or empty it is 0 next cycle.
//  - Minimum atomic latency is 2 cycles: push edge, then pop edge drives the port. One pop/cycle.
//  - Collision: popped head rd==main_rd!=0 with main_valid. The main result is younger and wins.
//    The head is popped and discarded (atomic_write_enable=0), so the regfile never sees rd==atomic_rd.
//  - Simultaneous push+pop (not full): count unchanged; pointers wrap modulo DEPTH.
//  - pending_mask = OR over valid FIFO entries of (1<<rd), plus (1<<atomic_rd) while
//    atomic_write_enable=1, with bit0 forced 0. It is combinational from state only, never from inputs.
//  - stall=1: both enables go 0 next cycle, FIFO holds and still accepts pushes until full.
// CONFIGURATION
//  WB_STATS_EN defined: adds outputs stat_main_wr, stat_atom_wr and stat_atom_drop (32-bit each).
//    They count issued main writes, issued atomic writes and collision discards.
//    They wrap at 2^32 and reset to 0.
//  WB_STATS_EN undefined: these ports and counters do not exist; all other behaviour is identical.
// STRUCTURE
//  cpu/defines.vh: REG_ADDR_W=5, XLEN default 32, REG_COUNT=32 shared with registers/decode.
//  Sub-module wb_fifo (DEPTH x {rd,data}) with push/pop/full/empty/count. It also exposes the
//  per-entry valid+rd vector from which the top builds pending_mask. The top holds the output regs,
//  the collision check and the stats.
// TESTING
//  1 reset low mid-run -> all outputs 0, pending_mask=0; after release atom_ready=1.
//  2 main_valid rd=5 data=0x1234 -> next cycle write_enable=1 rd=5 write_data=0x1234. Repeat with
//    rd=0 -> write_enable=0.
//  3 atom push rd=7 data=0xCAFE at edge N -> pending_mask[7]=1 from N. atomic_write_enable=1 with
//    rd=7 at N+1..N+2. pending_mask[7]=0 after the regfile write edge.
//  4 stall=1, push 4 atoms rd=1..4 -> atom_ready=0 after 4th, mask=0x1E. Release stall ->
//    writes rd=1,2,3,4 on consecutive cycles, in order.
//  5 head atom rd=3 and main_valid rd=3 same pop cycle -> write_enable=1 rd=3,
//    atomic_write_enable=0, mask[3] clears, stat_atom_drop=1 (WB_STATS_EN).
//  6 3 entries queued, assert reset -> FIFO empty, enables 0. Post-reset push rd=9 -> written
//    alone, no stale entries.

Source files
------------

// File: rtl/wb_writer_pkg.sv
// rtl/wb_writer_pkg.sv - shared register-file widths and helpers for the writeback writer
package wb_writer_pkg;

    localparam int REG_ADDR_W   = 5;
    localparam int REG_COUNT    = 32;
    localparam int XLEN_DEFAULT = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [REG_COUNT-1:0]  reg_mask_t;

    // x0 is hardwired, so it never shows up as a pending destination
    function automatic reg_mask_t rd_bit(input reg_addr_t r);
        rd_bit = '0;
        if (r != '0) rd_bit[r] = 1'b1;
    endfunction

endpackage

// File: rtl/wb_writer_if.sv
// rtl/wb_writer_if.sv - pipeline-side and regfile-side signals of the writeback writer
interface wb_writer_if #(
    parameter int XLEN = 32
);
    import wb_writer_pkg::*;

    logic            stall;
    logic            main_valid;
    reg_addr_t       main_rd;
    logic [XLEN-1:0] main_data;
    logic            atom_valid;
    logic            atom_ready;
    reg_addr_t       atom_rd;
    logic [XLEN-1:0] atom_data;
    logic            write_enable;
    reg_addr_t       rd;
    logic [XLEN-1:0] write_data;
    logic            atomic_write_enable;
    reg_addr_t       atomic_rd;
    logic [XLEN-1:0] atomic_write_data;
    reg_mask_t       pending_mask;

    modport master (
        output stall, main_valid, main_rd, main_data, atom_valid, atom_rd, atom_data,
        input  atom_ready, write_enable, rd, write_data,
        input  atomic_write_enable, atomic_rd, atomic_write_data, pending_mask
    );

    modport slave (
        input  stall, main_valid, main_rd, main_data, atom_valid, atom_rd, atom_data,
        output atom_ready, write_enable, rd, write_data,
        output atomic_write_enable, atomic_rd, atomic_write_data, pending_mask
    );

endinterface

// File: rtl/wb_writer_fifo.sv
// rtl/wb_writer_fifo.sv - atomic result FIFO (wb_fifo) exposing per-entry valid and rd
module wb_fifo
    import wb_writer_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  reg_addr_t                  push_rd_i,
    input  logic [XLEN-1:0]            push_data_i,
    input  logic                       pop_i,
    output reg_addr_t                  head_rd_o,
    output logic [XLEN-1:0]            head_data_o,
    output logic                       full_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       ent_valid_o [DEPTH],
    output reg_addr_t                  ent_rd_o    [DEPTH]
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    reg_addr_t        rd_mem_q   [DEPTH];
    logic [XLEN-1:0]  data_mem_q [DEPTH];
    logic             do_push, do_pop, empty;

    assign empty   = (count_q == '0);
    assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
    assign count_o = count_q;
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty;

    assign head_rd_o   = rd_mem_q[rd_ptr_q];
    assign head_data_o = data_mem_q[rd_ptr_q];

    // DEPTH is a power of two, so pointer overflow is the modulo wrap
    always_comb begin
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        if (do_push && !do_pop) count_d = count_q + 1'b1;
        if (do_pop && !do_push) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                rd_mem_q[i]   <= '0;
                data_mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (do_push) begin
                rd_mem_q[wr_ptr_q]   <= push_rd_i;
                data_mem_q[wr_ptr_q] <= push_data_i;
            end
        end
    end

    // An entry is live when its distance from the head is below the occupancy
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_valid_o[i] = ({1'b0, PTR_W'(i) - rd_ptr_q} < count_q);
            ent_rd_o[i]    = rd_mem_q[i];
        end
    end

endmodule

// File: rtl/wb_writer.sv
// rtl/wb_writer.sv - writeback driver for the dual-write-port register file
// Optional WB_STATS_EN adds stat_main_wr / stat_atom_wr / stat_atom_drop counters.
module wb_writer
    import wb_writer_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    wb_writer_if.slave  bus
`ifdef WB_STATS_EN
    ,
    output logic [31:0] stat_main_wr,
    output logic [31:0] stat_atom_wr,
    output logic [31:0] stat_atom_drop
`endif
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    reg_addr_t        head_rd;
    logic [XLEN-1:0]  head_data;
    logic             fifo_full;
    logic [CNT_W-1:0] fifo_count;
    logic             ent_valid [DEPTH];
    reg_addr_t        ent_rd    [DEPTH];

    logic pop, push, main_wr, collide, atom_wr;

    logic            we_q,    we_d;
    reg_addr_t       rd_q,    rd_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic            awe_q,   awe_d;
    reg_addr_t       ard_q,   ard_d;
    logic [XLEN-1:0] adata_q, adata_d;

    assign bus.atom_ready = reset && !fifo_full;

    wb_fifo #(.XLEN(XLEN), .DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .rst_n       (reset),
        .push_i      (push),
        .push_rd_i   (bus.atom_rd),
        .push_data_i (bus.atom_data),
        .pop_i       (pop),
        .head_rd_o   (head_rd),
        .head_data_o (head_data),
        .full_o      (fifo_full),
        .count_o     (fifo_count),
        .ent_valid_o (ent_valid),
        .ent_rd_o    (ent_rd)
    );

    // The main result is younger than anything queued, so on a collision the head is dropped
    always_comb begin
        pop     = !bus.stall && (fifo_count != '0);
        push    = bus.atom_valid && bus.atom_ready;
        main_wr = bus.main_valid && !bus.stall && (bus.main_rd != '0);
        collide = pop && main_wr && (head_rd == bus.main_rd);
        atom_wr = pop && (head_rd != '0) && !collide;
    end

    always_comb begin
        we_d    = main_wr;
        rd_d    = bus.main_rd;
        wdata_d = bus.main_data;
        awe_d   = atom_wr;
        ard_d   = pop ? head_rd   : ard_q;
        adata_d = pop ? head_data : adata_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            we_q    <= 1'b0;
            rd_q    <= '0;
            wdata_q <= '0;
            awe_q   <= 1'b0;
            ard_q   <= '0;
            adata_q <= '0;
        end else begin
            we_q    <= we_d;
            rd_q    <= rd_d;
            wdata_q <= wdata_d;
            awe_q   <= awe_d;
            ard_q   <= ard_d;
            adata_q <= adata_d;
        end
    end

    assign bus.write_enable        = we_q;
    assign bus.rd                  = rd_q;
    assign bus.write_data          = wdata_q;
    assign bus.atomic_write_enable = awe_q;
    assign bus.atomic_rd           = ard_q;
    assign bus.atomic_write_data   = adata_q;

    // Built from registered state only so decode never sees a same-cycle input loop
    always_comb begin
        bus.pending_mask = awe_q ? rd_bit(ard_q) : '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_valid[i]) bus.pending_mask = bus.pending_mask | rd_bit(ent_rd[i]);
        end
    end

`ifdef WB_STATS_EN
    logic [31:0] main_cnt_q, main_cnt_d;
    logic [31:0] atom_cnt_q, atom_cnt_d;
    logic [31:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        main_cnt_d = main_cnt_q + {31'd0, main_wr};
        atom_cnt_d = atom_cnt_q + {31'd0, atom_wr};
        drop_cnt_d = drop_cnt_q + {31'd0, collide};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            main_cnt_q <= '0;
            atom_cnt_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            main_cnt_q <= main_cnt_d;
            atom_cnt_q <= atom_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign stat_main_wr   = main_cnt_q;
    assign stat_atom_wr   = atom_cnt_q;
    assign stat_atom_drop = drop_cnt_q;
`endif

endmodule

// File: tb/tb_wb_writer.sv
// tb/tb_wb_writer.sv - randomized self-checking bench for wb_writer with a queue reference model
module tb_wb_writer;
    import wb_writer_pkg::*;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    wb_writer_if #(.XLEN(XLEN)) bus ();

`ifdef WB_STATS_EN
    logic [31:0] s_main, s_atom, s_drop;
`endif

    wb_writer #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef WB_STATS_EN
        ,
        .stat_main_wr   (s_main),
        .stat_atom_wr   (s_atom),
        .stat_atom_drop (s_drop)
`endif
    );

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    ent_t        q[$];
    logic        m_we, m_awe;
    logic [4:0]  m_rd, m_ard;
    logic [31:0] m_wdata, m_adata;
    logic [31:0] m_smain, m_satom, m_sdrop;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_mask();
        logic [31:0] m = '0;
        foreach (q[i]) m[q[i].rd] = 1'b1;
        if (m_awe) m[m_ard] = 1'b1;
        m[0] = 1'b0;
        return m;
    endfunction

    task automatic model_reset();
        q.delete();
        m_we = 0; m_awe = 0; m_rd = 0; m_ard = 0; m_wdata = 0; m_adata = 0;
        m_smain = 0; m_satom = 0; m_sdrop = 0;
    endtask

    task automatic compare_all(input string ph);
        check({ph, ".we"},    bus.write_enable, m_we);
        check({ph, ".rd"},    bus.rd, m_rd);
        check({ph, ".wdata"}, bus.write_data, m_wdata);
        check({ph, ".awe"},   bus.atomic_write_enable, m_awe);
        check({ph, ".ard"},   bus.atomic_rd, m_ard);
        check({ph, ".adata"}, bus.atomic_write_data, m_adata);
        check({ph, ".mask"},  bus.pending_mask, exp_mask());
        check({ph, ".ready"}, bus.atom_ready, (q.size() < DEPTH));
`ifdef WB_STATS_EN
        check({ph, ".smain"}, s_main, m_smain);
        check({ph, ".satom"}, s_atom, m_satom);
        check({ph, ".sdrop"}, s_drop, m_sdrop);
`endif
    endtask

    task automatic cycle(input string ph, input logic st, input logic mv, input logic [4:0] mrd,
                         input logic [31:0] md, input logic av, input logic [4:0] ar,
                         input logic [31:0] ad);
        logic full, pop, push, mw, col;
        ent_t h;
        bus.stall = st; bus.main_valid = mv; bus.main_rd = mrd; bus.main_data = md;
        bus.atom_valid = av; bus.atom_rd = ar; bus.atom_data = ad;
        full = (q.size() == DEPTH);
        pop  = !st && (q.size() > 0);
        h    = '{rd: 5'd0, data: 32'd0};
        if (pop) h = q[0];
        push = av && !full;
        mw   = mv && !st && (mrd != 0);
        col  = pop && mw && (h.rd == mrd);
        m_we = mw; m_rd = mrd; m_wdata = md;
        m_awe = pop && (h.rd != 0) && !col;
        if (pop) begin m_ard = h.rd; m_adata = h.data; end
        m_smain += {31'd0, mw};
        m_satom += {31'd0, m_awe};
        m_sdrop += {31'd0, col};
        if (pop)  void'(q.pop_front());
        if (push) q.push_back('{rd: ar, data: ad});
        @(posedge clk);
        @(negedge clk);
        compare_all(ph);
    endtask

    task automatic idle(input string ph, input int n);
        for (int i = 0; i < n; i++) cycle(ph, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset(input string ph);
        reset = 1'b0;
        bus.stall = 0; bus.main_valid = 0; bus.main_rd = 0; bus.main_data = 0;
        bus.atom_valid = 0; bus.atom_rd = 0; bus.atom_data = 0;
        #1;
        check({ph, ".rst_we"},    bus.write_enable, 0);
        check({ph, ".rst_awe"},   bus.atomic_write_enable, 0);
        check({ph, ".rst_wdata"}, bus.write_data, 0);
        check({ph, ".rst_mask"},  bus.pending_mask, 0);
        check({ph, ".rst_ready"}, bus.atom_ready, 0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        check({ph, ".post_ready"}, bus.atom_ready, 1);
        @(negedge clk);
    endtask

    initial begin
        model_reset();
        reset = 1'b1;
        @(negedge clk);
        do_reset("t1a");

        cycle("t2a", 0, 1, 5'd5, 32'h1234, 0, 0, 0);
        check("t2.we", bus.write_enable, 1);
        check("t2.rd", bus.rd, 5);
        check("t2.wdata", bus.write_data, 32'h1234);
        cycle("t2b", 0, 1, 5'd0, 32'h5678, 0, 0, 0);
        check("t2.we_x0", bus.write_enable, 0);

        cycle("t3a", 0, 0, 0, 0, 1, 5'd7, 32'hCAFE);
        check("t3.mask_q", bus.pending_mask[7], 1);
        idle("t3b", 1);
        check("t3.awe", bus.atomic_write_enable, 1);
        check("t3.ard", bus.atomic_rd, 7);
        idle("t3c", 1);
        check("t3.mask_clr", bus.pending_mask[7], 0);

        for (int i = 1; i <= 4; i++) cycle("t4a", 1, 0, 0, 0, 1, 5'(i), 32'h100 + i);
        check("t4.mask", bus.pending_mask, 32'h1E);
        check("t4.ready", bus.atom_ready, 0);
        cycle("t4b", 1, 0, 0, 0, 1, 5'd9, 32'hDEAD);
        for (int i = 1; i <= 4; i++) begin
            idle("t4c", 1);
            check("t4.order", bus.atomic_rd, i);
        end
        idle("t4d", 1);

        cycle("t5a", 1, 0, 0, 0, 1, 5'd3, 32'hA5A5);
        cycle("t5b", 0, 1, 5'd3, 32'h7777, 0, 0, 0);
        check("t5.we", bus.write_enable, 1);
        check("t5.awe", bus.atomic_write_enable, 0);
        check("t5.mask3", bus.pending_mask[3], 0);
`ifdef WB_STATS_EN
        check("t5.drop", s_drop, 1);
`endif

        for (int i = 0; i < 3; i++) cycle("t6a", 1, 0, 0, 0, 1, 5'(10 + i), 32'hB0 + i);
        do_reset("t6b");
        cycle("t6c", 0, 0, 0, 0, 1, 5'd9, 32'h9999);
        idle("t6d", 1);
        check("t6.ard", bus.atomic_rd, 9);
        idle("t6e", 3);

        for (int n = 0; n < 600; n++) begin
            if (n == 300) do_reset("rnd_rst");
            cycle("rnd",
                  ($urandom_range(3) == 0),
                  ($urandom_range(1) == 1),
                  5'($urandom_range(7)),
                  $urandom,
                  ($urandom_range(4) < 3),
                  5'($urandom_range(7)),
                  $urandom);
        end
        idle("drain", DEPTH + 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
